// File: rtl/mem_scan_pkg.sv
// Shared types and the checksum step for the memory sweep checker.
// The checksum is a 32-bit rotate-left-by-one followed by an XOR with the zero-extended word.
package mem_scan_pkg;

  localparam int CHK_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  function automatic logic [CHK_W-1:0] chk_step(input logic [CHK_W-1:0] acc,
                                                input logic [CHK_W-1:0] word);
    chk_step = {acc[CHK_W-2:0], acc[CHK_W-1]} ^ word;
  endfunction

endpackage

// File: rtl/mem_scan_checker_issue_pipe.sv
// Delay line of read-issue flags that lines each flag up with the memory data it requested.
// Stage 0 captures on the same edge the memory captures the address.
module issue_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic clear,
  input  logic in_valid,
  output logic out_valid
);

  logic [LAT-1:0] stage_r;

  // Shift issue flags by one stage per cycle; clear drops everything in flight.
  always_ff @(posedge clk) begin
    if (clear) begin
      stage_r <= '0;
    end else begin
      stage_r[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign out_valid = stage_r[LAT-1];

endmodule

// File: rtl/mem_scan_checker.sv
// Read-side sweep engine: walks every memory address, folds the returned words
// into a rotating checksum and compares it with a reference sampled at start.
module mem_scan_checker
  import mem_scan_pkg::*;
#(
  parameter int WID_MEM   = 8,
  parameter int DEPTH_MEM = 8192,
  parameter int RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hold,
  input  logic [CHK_W-1:0]   expected,
  output logic [CHK_W-1:0]   raddr,
  input  logic [WID_MEM-1:0] dout,
  output logic               busy,
  output logic               done,
  output logic [CHK_W-1:0]   checksum,
  output logic               match
);

  localparam int              AW         = $clog2(DEPTH_MEM);
  localparam logic [AW-1:0]   LAST_ADDR  = AW'(DEPTH_MEM - 1);
  localparam logic [1:0]      DRAIN_LAST = 2'(RD_LAT - 1);

  scan_state_t      state_r;
  scan_state_t      next_state_s;
  logic [AW-1:0]    addr_r;
  logic [1:0]       drain_r;
  logic [CHK_W-1:0] acc_r;
  logic [CHK_W-1:0] acc_next_s;
  logic [CHK_W-1:0] expected_q;
  logic [CHK_W-1:0] dout_ext_s;
  logic             issue_s;
  logic             accept_s;
  logic             finish_s;
  logic             ret_valid_s;

  assign dout_ext_s = CHK_W'(dout);
  assign raddr      = CHK_W'(addr_r);

  issue_pipe #(
    .LAT (RD_LAT)
  ) u_issue_pipe (
    .clk       (clk),
    .clear     (reset),
    .in_valid  (issue_s),
    .out_valid (ret_valid_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode plus the per-cycle issue / accept / finish strobes.
  always_comb begin
    next_state_s = state_r;
    issue_s      = 1'b0;
    accept_s     = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          accept_s     = 1'b1;
          next_state_s = SCAN;
        end else begin
          next_state_s = state_r;
        end
      end
      SCAN: begin
        if (!hold) begin
          issue_s = 1'b1;
          if (addr_r == LAST_ADDR) begin
            next_state_s = DRAIN;
          end else begin
            next_state_s = SCAN;
          end
        end else begin
          next_state_s = SCAN;
        end
      end
      DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          finish_s     = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Only words whose issue flag emerges from the pipe are folded in; held-cycle data is dropped.
  always_comb begin
    acc_next_s = acc_r;
    if (ret_valid_s) begin
      acc_next_s = chk_step(acc_r, dout_ext_s);
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Address counter, drain timer, accumulator and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r     <= '0;
      drain_r    <= 2'd0;
      acc_r      <= '0;
      expected_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      checksum   <= '0;
      match      <= 1'b0;
    end else begin
      busy <= (next_state_s == SCAN) || (next_state_s == DRAIN);
      done <= finish_s;
      if (accept_s) begin
        addr_r     <= '0;
        acc_r      <= '0;
        expected_q <= expected;
        match      <= 1'b0;
      end else begin
        acc_r <= acc_next_s;
        // The counter parks on the last address instead of wrapping.
        if (issue_s && (addr_r != LAST_ADDR)) begin
          addr_r <= addr_r + AW'(1);
        end
      end
      if (state_r == DRAIN) begin
        drain_r <= drain_r + 2'd1;
      end else begin
        drain_r <= 2'd0;
      end
      if (finish_s) begin
        checksum <= acc_next_s;
        match    <= (acc_next_s == expected_q);
      end
    end
  end

endmodule
